// File: rtl/clrcl_digit_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clrcl_digit_serial_adder: digit-serial add/subtract, LSB digit first,     |
// | with registered inter-digit carry and valid/ready on both sides.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module clrcl_digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] opa, opb, work, work_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic [DIGIT:0]   dsum;
  logic             c_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  // Operands shift right each digit, so the current digit is always the low
  // DIGIT bits and the operand MSBs sit at bit DIGIT-1 on the final digit.
  always_comb begin
    dsum  = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    last  = (cnt == CW'(NDIG - 1));
    c_msb = opa[DIGIT-1] ^ opb[DIGIT-1] ^ dsum[DIGIT-1];
    work_next = work;
    work_next[cnt*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      work  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= cin ^ sub;
      cnt   <= '0;
      work  <= '0;
    end else if (state == RUN) begin
      opa   <= opa >> DIGIT;
      opb   <= opb >> DIGIT;
      carry <= dsum[DIGIT];
      cnt   <= cnt + CW'(1);
      work  <= work_next;
      if (last) begin
        sum  <= work_next;
        cout <= dsum[DIGIT];
        ovf  <= c_msb ^ dsum[DIGIT];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clrcl_digit_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_clrcl_digit_serial_adder: directed bench for 16/4 and 16/16 configs.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_clrcl_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
  logic [15:0] a, b, sum;
  logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2, busy2;
  logic [15:0] a2, b2, sum2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clrcl_digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  clrcl_digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the 16/4 instance, including latency and consume.
  task automatic op1(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                     input logic tc, input logic ts, input logic [15:0] es,
                     input logic ec, input logic eo, input logic [15:0] prev);
    int n;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = ~tc; sub = ~ts;
    chk({tag, "_sum_hold"}, 32'(sum), 32'(prev));
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_consumed"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic op2(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                     input logic tc, input logic ts, input logic [15:0] es,
                     input logic ec, input logic eo);
    int n;
    @(negedge clk);
    a2 = ta; b2 = tb_; cin2 = tc; sub2 = ts; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd1);
    chk({tag, "_sum"}, 32'(sum2), 32'(es));
    chk({tag, "_cout"}, 32'(cout2), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf2), 32'(eo));
    @(negedge clk);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    chk({tag, "_consumed"}, 32'(out_valid2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  n;
    logic seen;
    rst_n = 1'b0;
    in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 0;
    in_valid2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0; out_ready2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    op1("add",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 16'h0000);
    op1("wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h2233);
    op1("povf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h0000);
    op1("sub",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h8000);
    op1("subov", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16'hFFFE);
    op1("addc",  16'h00FF, 16'h0100, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 16'h7FFF);
    op1("subb",  16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 16'h0200);

    // Back-pressure with an ignored operand pulse during the hold
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; cin = 0; sub = 0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", 32'(n), 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h5432);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_consumed", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    chk("bp_ignored_ops", 32'(seen), 32'd0);
    chk("bp_sum_kept", 32'(sum), 32'h5432);

    // Asynchronous reset after two digits of a run
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_out_valid", 32'(out_valid), 32'd0);
    chk("rr_sum", 32'(sum), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rr_no_result", 32'(seen), 32'd0);
    chk("rr_sum_zero", 32'(sum), 32'd0);

    // Single-digit configuration
    op2("d16_add",  16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);
    op2("d16_sub",  16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    op2("d16_novf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
